// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the two-port RAM arbiter: port IDs, response tag layout,
// error-cause bit positions and common byte-lane enable patterns.
package mem_arb_pkg;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  localparam int unsigned TAG_VALID_W = 1;
  localparam int unsigned TAG_PORT_W  = 1;
  localparam int unsigned TAG_READ_W  = 1;
  localparam int unsigned TAG_ERR_W   = 1;

  localparam int unsigned ERR_W        = 2;
  localparam int unsigned ERR_MISALIGN = 0;
  localparam int unsigned ERR_RANGE    = 1;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef struct packed {
    logic [TAG_VALID_W-1:0] valid;
    logic [TAG_PORT_W-1:0]  port;
    logic [TAG_READ_W-1:0]  is_read;
    logic [TAG_ERR_W-1:0]   err;
  } tag_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side bus of the RAM arbiter: request/grant handshake plus the response channel.
interface ram_port_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    req;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [DATA_WIDTH/8-1:0] wr_en;
  logic [DATA_WIDTH-1:0]   wdata;
  logic                    gnt;
  logic                    rvalid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    err;

  modport master (
    output req, addr, wr_en, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, wr_en, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant and a last-winner pointer that
// only moves when a grant is issued.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_q, last_d;

  always_comb begin
    gnt = 2'b00;
    if (reset_n) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == PORT_DBG) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
    last_d = last_q;
    if (|gnt) begin
      last_d = gnt[1];
    end
  end

  // Pointer resets to "debug won last" so the core port takes the first tie.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_q <= PORT_DBG;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one byte-write-enabled block RAM between the core and debug ports with round-robin
// arbitration, address checking, registered RAM issue and a two-stage response tag pipeline.
module ram_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS  = 1024,
  localparam int unsigned RAM_AW    = $clog2(MEM_WORDS),
  localparam int unsigned NUM_LANES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ram_port_arbiter_if.slave     m0,
  ram_port_arbiter_if.slave     m1,
  output logic [RAM_AW-1:0]     ram_addr,
  output logic [NUM_LANES-1:0]  ram_wr_en,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  logic [1:0]            req, gnt;
  logic                  granted, sel_port, issue_err;
  logic [ADDR_WIDTH-1:0] sel_addr, word_idx;
  logic [NUM_LANES-1:0]  sel_wr_en;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [ERR_W-1:0]      err_cause;

  logic [RAM_AW-1:0]     ram_addr_q, ram_addr_d;
  logic [NUM_LANES-1:0]  ram_wr_en_q, ram_wr_en_d;
  logic [DATA_WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  tag_t                  tag1_q, tag1_d, tag2_q;
  logic [1:0]            rsp_valid;
  logic                  rsp_has_data;

  assign req = {m1.req, m0.req};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  always_comb begin
    granted   = |gnt;
    sel_port  = gnt[1];
    sel_addr  = sel_port ? m1.addr  : m0.addr;
    sel_wr_en = sel_port ? m1.wr_en : m0.wr_en;
    sel_wdata = sel_port ? m1.wdata : m0.wdata;
    word_idx  = sel_addr >> 2;
    err_cause = '0;
    err_cause[ERR_MISALIGN] = |sel_addr[1:0];
    err_cause[ERR_RANGE]    = word_idx >= ADDR_WIDTH'(MEM_WORDS);
    issue_err = |err_cause;
  end

  // Bad accesses still get a grant and a response slot, but never a RAM write.
  always_comb begin
    ram_addr_d    = ram_addr_q;
    ram_wr_en_d   = '0;
    ram_data_in_d = ram_data_in_q;
    tag1_d        = '0;
    if (granted) begin
      ram_addr_d     = sel_addr[RAM_AW+1:2];
      ram_wr_en_d    = issue_err ? '0 : sel_wr_en;
      ram_data_in_d  = sel_wdata;
      tag1_d.valid   = 1'b1;
      tag1_d.port    = sel_port;
      tag1_d.is_read = (sel_wr_en == '0);
      tag1_d.err     = issue_err;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ram_addr_q    <= '0;
      ram_wr_en_q   <= '0;
      ram_data_in_q <= '0;
      tag1_q        <= '0;
      tag2_q        <= '0;
    end else begin
      ram_addr_q    <= ram_addr_d;
      ram_wr_en_q   <= ram_wr_en_d;
      ram_data_in_q <= ram_data_in_d;
      tag1_q        <= tag1_d;
      tag2_q        <= tag1_q;
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_wr_en   = ram_wr_en_q;
  assign ram_data_in = ram_data_in_q;

  // Tag stage 2 lines up with the RAM's one-cycle read latency.
  always_comb begin
    rsp_valid[0] = tag2_q.valid && (tag2_q.port == PORT_CORE);
    rsp_valid[1] = tag2_q.valid && (tag2_q.port == PORT_DBG);
    rsp_has_data = tag2_q.is_read && !tag2_q.err;
  end

  assign m0.gnt    = gnt[0];
  assign m0.rvalid = rsp_valid[0];
  assign m0.err    = rsp_valid[0] && tag2_q.err;
  assign m0.rdata  = (rsp_valid[0] && rsp_has_data) ? ram_data_out : '0;

  assign m1.gnt    = gnt[1];
  assign m1.rvalid = rsp_valid[1];
  assign m1.err    = rsp_valid[1] && tag2_q.err;
  assign m1.rdata  = (rsp_valid[1] && rsp_has_data) ? ram_data_out : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: behavioural RAM, directed table, reset/contention sequences and
// a randomized run against a transaction-level model of arbitration, memory and responses.
module tb_ram_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned WORDS = 1024;
  localparam int unsigned RAW   = 10;
  localparam int          NRAND = 3000;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
  ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();

  logic [RAW-1:0] ram_addr;
  logic [3:0]     ram_wr_en;
  logic [DW-1:0]  ram_data_in, ram_data_out;

  ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(WORDS)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .m0           (m0_if),
    .m1           (m1_if),
    .ram_addr     (ram_addr),
    .ram_wr_en    (ram_wr_en),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out)
  );

  function automatic logic [31:0] init_word(input int i);
    if (i == 64)   return 32'hDEADBEEF;
    if (i == 65)   return 32'h12345678;
    if (i == 1023) return 32'hCAFE0000;
    return {16'h5A5A, 16'(i)};
  endfunction

  // Behavioural block RAM: write-first, read data one cycle after the address.
  logic        ram_load;
  logic [31:0] ram [WORDS];
  logic [31:0] ram_merged;

  always_comb begin
    ram_merged = ram[ram_addr];
    for (int b = 0; b < 4; b++) begin
      if (ram_wr_en[b]) ram_merged[8*b +: 8] = ram_data_in[8*b +: 8];
    end
  end

  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < WORDS; i++) ram[i] <= init_word(i);
      ram_data_out <= '0;
    end else begin
      if (|ram_wr_en) ram[ram_addr] <= ram_merged;
      ram_data_out <= ram_merged;
    end
  end

  // Transaction-level reference model.
  logic [31:0] model_mem [WORDS];
  int          last_port;

  typedef struct {
    int          due;
    int          port;
    logic        err;
    logic [31:0] rdata;
  } rsp_t;
  rsp_t rsp_q[$];

  function automatic logic addr_err(input logic [31:0] a);
    return (a % 4 != 0) || ((a / 4) >= WORDS);
  endfunction

  function automatic logic [31:0] expected_rd(input logic [31:0] a, input logic [3:0] be);
    if (addr_err(a) || be != 4'b0) return 32'h0;
    return model_mem[a / 4];
  endfunction

  task automatic model_commit(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
    logic [31:0] w;
    if (!addr_err(a) && be != 4'b0) begin
      w = model_mem[a / 4];
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      model_mem[a / 4] = w;
    end
  endtask

  int checks, errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input logic rq, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    if (p == 0) begin
      m0_if.req = rq; m0_if.addr = a; m0_if.wr_en = be; m0_if.wdata = d;
    end else begin
      m1_if.req = rq; m1_if.addr = a; m1_if.wr_en = be; m1_if.wdata = d;
    end
  endtask

  function automatic logic get_gnt(input int p);
    return (p == 0) ? m0_if.gnt : m1_if.gnt;
  endfunction
  function automatic logic get_rvalid(input int p);
    return (p == 0) ? m0_if.rvalid : m1_if.rvalid;
  endfunction
  function automatic logic get_err(input int p);
    return (p == 0) ? m0_if.err : m1_if.err;
  endfunction
  function automatic logic [31:0] get_rdata(input int p);
    return (p == 0) ? m0_if.rdata : m1_if.rdata;
  endfunction

  typedef struct packed {
    logic        port;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [9:0]  exp_ram_addr;
    logic [3:0]  exp_wr_en;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vecs [12];

  // One isolated access: grant at N, RAM issue visible at N+1, response at N+2.
  task automatic run_vec(input int i);
    vec_t v;
    int   p;
    v = vecs[i];
    p = int'(v.port);
    step();
    drive(p, 1'b1, v.addr, v.be, v.wdata);
    @(negedge clk);
    check($sformatf("vec%0d_gnt", i), 32'(get_gnt(p)), 32'd1);
    check($sformatf("vec%0d_gnt_other", i), 32'(get_gnt(1 - p)), 32'd0);
    model_commit(v.addr, v.be, v.wdata);
    step();
    drive(p, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    check($sformatf("vec%0d_ram_addr", i), 32'(ram_addr), 32'(v.exp_ram_addr));
    check($sformatf("vec%0d_ram_wr_en", i), 32'(ram_wr_en), 32'(v.exp_wr_en));
    step();
    @(negedge clk);
    check($sformatf("vec%0d_rvalid", i), 32'(get_rvalid(p)), 32'd1);
    check($sformatf("vec%0d_err", i), 32'(get_err(p)), 32'(v.exp_err));
    check($sformatf("vec%0d_rdata", i), get_rdata(p), v.exp_rdata);
    check($sformatf("vec%0d_rvalid_other", i), 32'(get_rvalid(1 - p)), 32'd0);
  endtask

  logic        pend [2];
  logic [31:0] p_addr [2];
  logic [3:0]  p_be [2];
  logic [31:0] p_d [2];
  int          c_port [4];
  logic [31:0] c_rd [4];
  int          c_idx [2];

  initial begin : main
    rsp_t        r;
    logic        exp_v [2];
    logic        exp_e [2];
    logic [31:0] exp_d [2];
    int          win, p, j, bad;
    logic [31:0] a;

    checks = 0; errors = 0;
    ram_load = 1'b1;
    reset_n  = 1'b0;
    drive(0, 1'b1, 32'h200, 4'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
    for (int i = 0; i < WORDS; i++) model_mem[i] = init_word(i);

    vecs[0]  = '{1'b0, 32'h100,  4'b0000, 32'h0,        10'd64,   4'b0000, 1'b0, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 32'h104,  4'b0000, 32'h0,        10'd65,   4'b0000, 1'b0, 32'h12345678};
    vecs[2]  = '{1'b1, 32'h104,  4'b0100, 32'h00AB0000, 10'd65,   4'b0100, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h104,  4'b0000, 32'h0,        10'd65,   4'b0000, 1'b0, 32'h12AB5678};
    vecs[4]  = '{1'b0, 32'h102,  BE_WORD, 32'hFFFFFFFF, 10'd64,   4'b0000, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h1000, BE_WORD, 32'hFFFFFFFF, 10'd0,    4'b0000, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h100,  4'b0000, 32'h0,        10'd64,   4'b0000, 1'b0, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 32'hFFC,  BE_HALF, 32'h1234BEEF, 10'd1023, 4'b0011, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'hFFC,  4'b0000, 32'h0,        10'd1023, 4'b0000, 1'b0, 32'hCAFEBEEF};
    vecs[9]  = '{1'b0, 32'h1001, 4'b0000, 32'h0,        10'd0,    4'b0000, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 32'h0,    4'b1000, 32'hAA000000, 10'd0,    4'b1000, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0,    4'b0000, 32'h0,        10'd0,    4'b0000, 1'b0, 32'hAA5A0000};

    // Reset held with a pending request.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst%0d_gnt0", k), 32'(m0_if.gnt), 32'd0);
      check($sformatf("rst%0d_ram_wr_en", k), 32'(ram_wr_en), 32'd0);
      check($sformatf("rst%0d_rvalid0", k), 32'(m0_if.rvalid), 32'd0);
    end
    step();
    ram_load = 1'b0;
    reset_n  = 1'b1;
    @(negedge clk);
    check("rst_release_gnt0", 32'(m0_if.gnt), 32'd1);
    step();
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    step();
    @(negedge clk);
    check("rst_release_rvalid0", 32'(m0_if.rvalid), 32'd1);
    check("rst_release_rdata0", m0_if.rdata, expected_rd(32'h200, 4'h0));

    for (int i = 0; i < 12; i++) run_vec(i);

    // Reset one cycle after a core grant: response must vanish.
    step();
    drive(0, 1'b1, 32'h100, 4'h0, 32'h0);
    @(negedge clk);
    check("mid_gnt0", 32'(m0_if.gnt), 32'd1);
    step();
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    @(negedge clk);
    check("mid_rvalid0", 32'(m0_if.rvalid), 32'd0);
    check("mid_rvalid1", 32'(m1_if.rvalid), 32'd0);

    // Contention straight after reset: the core must win the first tie.
    c_idx[0] = 0; c_idx[1] = 0;
    for (int k = 0; k < 6; k++) begin
      step();
      if (k < 4) begin
        drive(0, 1'b1, 32'h100 + 32'(8 * c_idx[0]), 4'h0, 32'h0);
        drive(1, 1'b1, 32'h104 + 32'(8 * c_idx[1]), 4'h0, 32'h0);
      end else begin
        drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
        drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
      end
      @(negedge clk);
      if (k < 4) begin
        p = k % 2;
        check($sformatf("cont%0d_gnt0", k), 32'(m0_if.gnt), 32'(p == 0));
        check($sformatf("cont%0d_gnt1", k), 32'(m1_if.gnt), 32'(p == 1));
        c_port[k] = p;
        c_rd[k]   = expected_rd(32'h100 + 32'(4 * p) + 32'(8 * c_idx[p]), 4'h0);
        c_idx[p]++;
      end
      if (k >= 2) begin
        j = k - 2;
        check($sformatf("cont%0d_rvalid0", k), 32'(m0_if.rvalid), 32'(c_port[j] == 0));
        check($sformatf("cont%0d_rvalid1", k), 32'(m1_if.rvalid), 32'(c_port[j] == 1));
        check($sformatf("cont%0d_rdata", k), get_rdata(c_port[j]), c_rd[j]);
      end else begin
        check($sformatf("cont%0d_no_rsp", k), 32'({m1_if.rvalid, m0_if.rvalid}), 32'd0);
      end
    end

    // Randomized traffic against the model.
    step();
    reset_n = 1'b0;
    step();
    reset_n   = 1'b1;
    last_port = 1;
    rsp_q.delete();
    pend[0] = 1'b0; pend[1] = 1'b0;
    for (int cyc = 0; cyc < NRAND + 4; cyc++) begin
      step();
      for (int q = 0; q < 2; q++) begin
        if (!pend[q]) begin
          if (cyc < NRAND && $urandom_range(0, 1) == 1) begin
            pend[q] = 1'b1;
            case ($urandom_range(0, 9))
              0: a = {20'h0, 10'($urandom_range(0, 1023)), 2'($urandom_range(1, 3))};
              1: a = ($urandom() | 32'h0000_1000) & 32'hFFFF_FFFC;
              2: a = 32'hFFC;
              default: a = 32'($urandom_range(0, 31)) << 2;
            endcase
            p_addr[q] = a;
            case ($urandom_range(0, 5))
              0, 1: p_be[q] = 4'b0000;
              2: p_be[q] = 4'(BE_BYTE << $urandom_range(0, 3));
              3: p_be[q] = 4'(BE_HALF << (2 * $urandom_range(0, 1)));
              default: p_be[q] = BE_WORD;
            endcase
            p_d[q] = $urandom();
          end
        end else if ($urandom_range(0, 9) == 0) begin
          pend[q] = 1'b0;
        end
        drive(q, pend[q], p_addr[q], p_be[q], p_d[q]);
      end
      @(negedge clk);
      for (int q = 0; q < 2; q++) begin
        exp_v[q] = 1'b0; exp_e[q] = 1'b0; exp_d[q] = 32'h0;
      end
      if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
        r = rsp_q.pop_front();
        exp_v[r.port] = 1'b1;
        exp_e[r.port] = r.err;
        exp_d[r.port] = r.rdata;
      end
      for (int q = 0; q < 2; q++) begin
        check($sformatf("rnd%0d_rvalid%0d", cyc, q), 32'(get_rvalid(q)), 32'(exp_v[q]));
        check($sformatf("rnd%0d_err%0d", cyc, q), 32'(get_err(q)), 32'(exp_e[q]));
        check($sformatf("rnd%0d_rdata%0d", cyc, q), get_rdata(q), exp_d[q]);
      end
      win = -1;
      if (pend[0] && pend[1]) win = (last_port == 1) ? 0 : 1;
      else if (pend[0])       win = 0;
      else if (pend[1])       win = 1;
      for (int q = 0; q < 2; q++) begin
        check($sformatf("rnd%0d_gnt%0d", cyc, q), 32'(get_gnt(q)), 32'(win == q));
      end
      if (win >= 0) begin
        r.due   = cyc + 2;
        r.port  = win;
        r.err   = addr_err(p_addr[win]);
        r.rdata = expected_rd(p_addr[win], p_be[win]);
        rsp_q.push_back(r);
        model_commit(p_addr[win], p_be[win], p_d[win]);
        last_port = win;
        pend[win] = 1'b0;
      end
    end
    step();
    drive(0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 32'h0, 4'h0, 32'h0);
    step();

    bad = 0;
    for (int i = 0; i < WORDS; i++) if (ram[i] !== model_mem[i]) bad++;
    check("ram_contents_mismatched_words", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
